// File: rtl/temporizador_jogada_if.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_jogada_if
//  Description : Control and status bundle of the per-move timeout timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface temporizador_jogada_if #(
    parameter int N = 4
);
    logic         iniciar;
    logic         tick;
    logic         pausar;
    logic         jogada_feita;
    logic [N-1:0] tempo_restante;
    logic         ativo;
    logic         alerta;
    logic         timeout;
    logic [1:0]   estado_db;

    // Master is the game control side; slave is the timer itself.
    modport master (
        output iniciar, tick, pausar, jogada_feita,
        input  tempo_restante, ativo, alerta, timeout, estado_db
    );

    modport slave (
        input  iniciar, tick, pausar, jogada_feita,
        output tempo_restante, ativo, alerta, timeout, estado_db
    );
endinterface
`default_nettype wire

// File: rtl/temporizador_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_jogada
//  Description : Per-move countdown timer with pause, cancel, early warning
//                and a single-cycle timeout pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporizador_jogada #(
    parameter int LIMITE = 5,
    parameter int ALERTA = 2,
    parameter int N      = 4
) (
    input  wire                    clock,
    input  wire                    zera_as_n,
    temporizador_jogada_if.slave   bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        ESGOTADO = 2'b11
    } estado_t;

    localparam logic [N-1:0] c_LIMITE = N'(LIMITE);
    localparam logic [N-1:0] c_ALERTA = N'(ALERTA);
    localparam logic [N-1:0] c_UM     = N'(1);

    estado_t      r_estado;
    logic [N-1:0] r_tempo;
    logic         r_timeout;
    logic         w_ativo;
    logic         w_alerta;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado  <= OCIOSO;
            r_tempo   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        r_estado <= CONTANDO;
                        r_tempo  <= c_LIMITE;
                    end
                end

                // A move beats even the final tick; a pause swallows a
                // tick sampled in the same cycle.
                CONTANDO: begin
                    if (bus.iniciar) begin
                        r_tempo <= c_LIMITE;
                    end else if (bus.jogada_feita) begin
                        r_estado <= OCIOSO;
                    end else if (bus.pausar) begin
                        r_estado <= PAUSADO;
                    end else if (bus.tick) begin
                        if (r_tempo > c_UM) begin
                            r_tempo <= r_tempo - c_UM;
                        end else begin
                            r_tempo   <= '0;
                            r_estado  <= ESGOTADO;
                            r_timeout <= 1'b1;
                        end
                    end
                end

                PAUSADO: begin
                    if (bus.iniciar) begin
                        r_estado <= CONTANDO;
                        r_tempo  <= c_LIMITE;
                    end else if (bus.jogada_feita) begin
                        r_estado <= OCIOSO;
                    end else if (!bus.pausar) begin
                        r_estado <= CONTANDO;
                    end
                end

                ESGOTADO: begin
                    if (bus.iniciar) begin
                        r_estado <= CONTANDO;
                        r_tempo  <= c_LIMITE;
                    end
                end

                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign w_ativo  = (r_estado == CONTANDO) || (r_estado == PAUSADO);
    assign w_alerta = w_ativo && (r_tempo != '0) && (r_tempo <= c_ALERTA);

    assign bus.tempo_restante = r_tempo;
    assign bus.timeout        = r_timeout;
    assign bus.ativo          = w_ativo;
    assign bus.alerta         = w_alerta;
    assign bus.estado_db      = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporizador_jogada
//  Description : Scoreboard bench for temporizador_jogada (LIMITE=5, ALERTA=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador_jogada;

    localparam logic [3:0] c_Z = 4'b0000;
    localparam logic [3:0] c_I = 4'b1000;
    localparam logic [3:0] c_T = 4'b0100;
    localparam logic [3:0] c_P = 4'b0010;
    localparam logic [3:0] c_J = 4'b0001;

    localparam logic [1:0] c_OC = 2'b00;
    localparam logic [1:0] c_CO = 2'b01;
    localparam logic [1:0] c_PA = 2'b10;
    localparam logic [1:0] c_ES = 2'b11;

    typedef struct {
        logic [3:0] t;
        logic       a;
        logic       al;
        logic       to;
        logic [1:0] st;
        string      nm;
    } exp_t;

    logic clock;
    logic zera_as_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q_sync[$];
    exp_t q_async[$];
    exp_t r_me;
    exp_t r_ma;
    event ev_async;

    temporizador_jogada_if #(.N(4)) bus ();

    temporizador_jogada #(.LIMITE(5), .ALERTA(2), .N(4)) u_dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .bus       (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input exp_t e);
        n_chk++;
        if (bus.tempo_restante === e.t && bus.ativo === e.a && bus.alerta === e.al &&
            bus.timeout === e.to && bus.estado_db === e.st) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got t=%0d ativo=%b alerta=%b timeout=%b estado=%b, expected t=%0d ativo=%b alerta=%b timeout=%b estado=%b",
                     e.nm, bus.tempo_restante, bus.ativo, bus.alerta, bus.timeout, bus.estado_db,
                     e.t, e.a, e.al, e.to, e.st);
        end
    endtask

    // Synchronous monitor: one expectation per cycle in which one was issued.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (q_sync.size() > 0) begin
                r_me = q_sync.pop_front();
                compare(r_me);
            end
        end
    end

    initial begin
        forever begin
            @(ev_async);
            if (q_async.size() > 0) begin
                r_ma = q_async.pop_front();
                compare(r_ma);
            end
        end
    end

    // Drive inputs at the falling edge; the expectation is for the next rise.
    task automatic step(input logic [3:0] v, input bit chk, input logic [3:0] t,
                        input logic a, input logic al, input logic to,
                        input logic [1:0] st, input string nm);
        exp_t e;
        @(negedge clock);
        {bus.iniciar, bus.tick, bus.pausar, bus.jogada_feita} = v;
        if (chk) begin
            e.t = t; e.a = a; e.al = al; e.to = to; e.st = st; e.nm = nm;
            q_sync.push_back(e);
        end
    endtask

    task automatic go(input logic [3:0] v);
        step(v, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, c_OC, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ea;
        zera_as_n = 1'b0;
        {bus.iniciar, bus.tick, bus.pausar, bus.jogada_feita} = c_Z;
        repeat (3) @(posedge clock);
        @(negedge clock);
        zera_as_n = 1'b1;
        step(c_Z, 1, 4'd0, 0, 0, 0, c_OC, "reset");
        step(c_T, 1, 4'd0, 0, 0, 0, c_OC, "idle_tick");

        // Test 1: full countdown, ticks 10 cycles apart
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t1_start");
        for (int i = 0; i < 9; i++) go(c_Z);
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t1_4");
        step(c_Z, 1, 4'd4, 1, 0, 0, c_CO, "t1_hold4");
        for (int i = 0; i < 8; i++) go(c_Z);
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t1_3");
        for (int i = 0; i < 9; i++) go(c_Z);
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t1_2");
        for (int i = 0; i < 9; i++) go(c_Z);
        step(c_T, 1, 4'd1, 1, 1, 0, c_CO, "t1_1");
        for (int i = 0; i < 9; i++) go(c_Z);
        step(c_T, 1, 4'd0, 0, 0, 1, c_ES, "t1_timeout");
        step(c_Z, 1, 4'd0, 0, 0, 0, c_ES, "t1_pulse_end");
        step(c_T, 1, 4'd0, 0, 0, 0, c_ES, "t1_esg_tick");

        // Test 2: pause with ticks inside, registered resume
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t2_start");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t2_4");
        go(c_Z);
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t2_3");
        step(c_P | c_T, 1, 4'd3, 1, 0, 0, c_PA, "t2_pause_tick_lost");
        for (int i = 1; i < 30; i++) begin
            if (i == 5 || i == 15 || i == 25)
                step(c_P | c_T, 1, 4'd3, 1, 0, 0, c_PA, "t2_paused_tick");
            else
                go(c_P);
        end
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t2_resume_tick_lost");
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t2_2");
        step(c_T, 1, 4'd1, 1, 1, 0, c_CO, "t2_1");
        step(c_T, 1, 4'd0, 0, 0, 1, c_ES, "t2_timeout");
        step(c_Z, 1, 4'd0, 0, 0, 0, c_ES, "t2_pulse_end");

        // Test 3: move beats the final tick
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t3_start");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t3_4");
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t3_3");
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t3_2");
        step(c_T, 1, 4'd1, 1, 1, 0, c_CO, "t3_1");
        step(c_J | c_T, 1, 4'd1, 0, 0, 0, c_OC, "t3_move");
        step(c_T, 1, 4'd1, 0, 0, 0, c_OC, "t3_idle_hold");

        // Test 4: exit from ESGOTADO, reload priority, pause interactions
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t4_start");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t4_4");
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t4_3");
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t4_2");
        step(c_T, 1, 4'd1, 1, 1, 0, c_CO, "t4_1");
        step(c_T, 1, 4'd0, 0, 0, 1, c_ES, "t4_timeout");
        step(c_J, 1, 4'd0, 0, 0, 0, c_ES, "t4_esg_move");
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t4_restart");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t4_r4");
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t4_r3");
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t4_r2");
        step(c_I | c_T, 1, 4'd5, 1, 0, 0, c_CO, "t4_reload_with_tick");
        step(c_P, 1, 4'd5, 1, 0, 0, c_PA, "t4_pause");
        step(c_I | c_P, 1, 4'd5, 1, 0, 0, c_CO, "t4_pause_restart");
        step(c_J | c_P, 1, 4'd5, 0, 0, 0, c_OC, "t4_move_over_pause");
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t4_start2");
        step(c_P, 1, 4'd5, 1, 0, 0, c_PA, "t4_pause2");
        step(c_J | c_P, 1, 4'd5, 0, 0, 0, c_OC, "t4_move_in_pause");

        // Test 5: asynchronous reset between edges
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t5_start");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t5_4");
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t5_3");
        go(c_Z);
        @(posedge clock);
        #3;
        zera_as_n = 1'b0;
        #1;
        ea.t = 4'd0; ea.a = 1'b0; ea.al = 1'b0; ea.to = 1'b0; ea.st = c_OC; ea.nm = "t5_async_reset";
        q_async.push_back(ea);
        -> ev_async;
        @(negedge clock);
        zera_as_n = 1'b1;
        step(c_T, 1, 4'd0, 0, 0, 0, c_OC, "t5_tick_after_reset");
        step(c_T, 1, 4'd0, 0, 0, 0, c_OC, "t5_tick_after_reset2");

        // Test 6: tick held high three cycles
        step(c_I, 1, 4'd5, 1, 0, 0, c_CO, "t6_start");
        step(c_T, 1, 4'd4, 1, 0, 0, c_CO, "t6_4");
        step(c_T, 1, 4'd3, 1, 0, 0, c_CO, "t6_3");
        step(c_T, 1, 4'd2, 1, 1, 0, c_CO, "t6_2");
        step(c_Z, 1, 4'd2, 1, 1, 0, c_CO, "t6_hold");

        @(posedge clock);
        #5;
        n_chk++;
        if (q_sync.size() == 0 && q_async.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d pending expectations, expected 0", q_sync.size() + q_async.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
